// File: rtl/io_port_pkg.sv
// rtl/io_port_pkg.sv - shared defaults and lowest-set-bit select for io_port_ctrl
package io_port_pkg;

    localparam int NUIOIN_DEF = 4;
    localparam int NUIOOU_DEF = 4;
    localparam int NBIN_DEF   = 19;
    localparam int NBOUT_DEF  = 28;
    localparam int DEPTH_DEF  = 4;

    // Index of the lowest set bit, or -1 when no bit is set. Used to reduce
    // (illegal) multi-hot strobes to a single serviced port.
    function automatic int lsb_index(input logic [31:0] v);
        int idx;
        idx = -1;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/port_fifo.sv
// rtl/port_fifo.sv - first-word-fall-through sample FIFO for one input port
// Ports: clk, rst (async active-low), push/wdata write side,
//        pop/rdata read side (rdata is the current head), full, empty.
module port_fifo #(
    parameter int NBIN  = 19,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [NBIN-1:0] wdata,
    input  logic            pop,
    output logic [NBIN-1:0] rdata,
    output logic            full,
    output logic            empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the
    // address bits coincide.
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [NBIN-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset: pointer reset alone makes the contents invisible.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/io_port_ctrl.sv
// rtl/io_port_ctrl.sv - I/O port controller between sample streams and core port strobes
// Ports: clk, rst (async active-low); s_data/s_valid/s_ready input streams;
//        req_in/io_in core input read; out_en/io_out core output write;
//        m_data/m_valid/m_ready output drain; clr_err, underflow, overflow flags.
module io_port_ctrl
    import io_port_pkg::*;
#(
    parameter int NUIOIN = NUIOIN_DEF,
    parameter int NUIOOU = NUIOOU_DEF,
    parameter int NBIN   = NBIN_DEF,
    parameter int NBOUT  = NBOUT_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUIOIN*NBIN-1:0]   s_data,
    input  logic [NUIOIN-1:0]        s_valid,
    output logic [NUIOIN-1:0]        s_ready,
    input  logic [NUIOIN-1:0]        req_in,
    output logic [NBIN-1:0]          io_in,
    input  logic [NUIOOU-1:0]        out_en,
    input  logic [NBOUT-1:0]         io_out,
    output logic [NUIOOU*NBOUT-1:0]  m_data,
    output logic [NUIOOU-1:0]        m_valid,
    input  logic [NUIOOU-1:0]        m_ready,
    input  logic                     clr_err,
    output logic [NUIOIN-1:0]        underflow,
    output logic [NUIOOU-1:0]        overflow
);

    logic [NUIOIN-1:0] full;
    logic [NUIOIN-1:0] empty;
    logic [NUIOIN-1:0] push;
    logic [NUIOIN-1:0] pop;
    logic [NUIOIN-1:0] sel_in;
    logic [NUIOOU-1:0] sel_out;
    logic [NUIOIN-1:0] uf_set;
    logic [NUIOOU-1:0] of_set;
    logic [NBIN-1:0]   head [NUIOIN];
    int                in_idx;
    int                out_idx;

    assign in_idx  = lsb_index(32'(req_in));
    assign out_idx = lsb_index(32'(out_en));

    always_comb begin
        sel_in  = '0;
        sel_out = '0;
        for (int k = 0; k < NUIOIN; k++) if (in_idx == k)  sel_in[k]  = 1'b1;
        for (int k = 0; k < NUIOOU; k++) if (out_idx == k) sel_out[k] = 1'b1;
    end

    // s_ready ignores a same-cycle pop, so a full FIFO always refuses.
    assign s_ready = {NUIOIN{rst}} & ~full;
    assign push    = s_valid & s_ready;
    assign pop     = sel_in & ~empty;
    assign uf_set  = sel_in & empty;

    for (genvar k = 0; k < NUIOIN; k++) begin : g_fifo
        port_fifo #(.NBIN(NBIN), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[k]),
            .wdata (s_data[k*NBIN +: NBIN]),
            .pop   (pop[k]),
            .rdata (head[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

    // Empty or unselected ports read as zero.
    always_comb begin
        io_in = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (pop[k]) io_in = head[k];
        end
    end

    // A capture consumes the old value when the sink is ready in the same cycle.
    assign of_set = sel_out & m_valid & ~m_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_data    <= '0;
            m_valid   <= '0;
            underflow <= '0;
            overflow  <= '0;
        end else begin
            for (int k = 0; k < NUIOOU; k++) begin
                if (sel_out[k]) begin
                    m_data[k*NBOUT +: NBOUT] <= io_out;
                    m_valid[k]               <= 1'b1;
                end else if (m_ready[k]) begin
                    m_valid[k] <= 1'b0;
                end
            end
            // New events win over a coincident clear.
            underflow <= (clr_err ? '0 : underflow) | uf_set;
            overflow  <= (clr_err ? '0 : overflow)  | of_set;
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// tb/tb_io_port_ctrl.sv - scoreboard testbench for io_port_ctrl
module tb_io_port_ctrl;

    localparam int NUIOIN = 4;
    localparam int NUIOOU = 4;
    localparam int NBIN   = 19;
    localparam int NBOUT  = 28;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUIOIN*NBIN-1:0]  s_data;
    logic [NUIOIN-1:0]       s_valid;
    logic [NUIOIN-1:0]       s_ready;
    logic [NUIOIN-1:0]       req_in;
    logic [NBIN-1:0]         io_in;
    logic [NUIOOU-1:0]       out_en;
    logic [NBOUT-1:0]        io_out;
    logic [NUIOOU*NBOUT-1:0] m_data;
    logic [NUIOOU-1:0]       m_valid;
    logic [NUIOOU-1:0]       m_ready;
    logic                    clr_err;
    logic [NUIOIN-1:0]       underflow;
    logic [NUIOOU-1:0]       overflow;

    int vectors = 0;
    int miscompares = 0;

    logic [NBIN-1:0]  q_in  [$];
    logic [NBOUT-1:0] q_out [$];

    io_port_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .req_in    (req_in),
        .io_in     (io_in),
        .out_en    (out_en),
        .io_out    (io_out),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .clr_err   (clr_err),
        .underflow (underflow),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input int k, input logic [NBIN-1:0] v);
        s_data[k*NBIN +: NBIN] = v;
        s_valid[k] = 1'b1;
        q_in.push_back(v);
    endtask

    task automatic read_in(input string tag);
        logic [NBIN-1:0] e;
        #1;
        if (q_in.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = q_in.pop_front();
            check(tag, 32'(io_in), 32'(e));
        end
    endtask

    task automatic capture(input int k, input logic [NUIOOU-1:0] en, input logic [NBOUT-1:0] v);
        out_en = en;
        io_out = v;
        q_out.push_back(v);
        tick();
        out_en = '0;
        if (q_out.size() != 0) check("m_data", 32'(m_data[k*NBOUT +: NBOUT]), 32'(q_out.pop_front()));
    endtask

    initial begin
        rst = 1'b0;
        s_data = '0; s_valid = '0; req_in = '0; out_en = '0;
        io_out = '0; m_ready = '0; clr_err = 1'b0;
        tick(); tick();
        check("rst_s_ready", 32'(s_ready), 32'h0);
        check("rst_io_in", 32'(io_in), 32'h0);
        check("rst_m_valid", 32'(m_valid), 32'h0);
        check("rst_m_data", 32'(m_data[31:0]), 32'h0);
        check("rst_flags", {24'h0, underflow, overflow}, 32'h0);
        rst = 1'b1;
        tick();
        check("s_ready_up", 32'(s_ready), 32'hf);

        // port 2: 5, -3, 7 in, read back in order
        drive_in(2, 19'd5);      tick();
        drive_in(2, 19'h7FFFD);  tick();
        drive_in(2, 19'd7);      tick();
        s_valid = '0;
        req_in = 4'b0100;
        read_in("p2_0"); tick();
        read_in("p2_1"); tick();
        read_in("p2_2"); tick();
        req_in = '0;
        check("p2_no_uf", 32'(underflow), 32'h0);
        req_in = 4'b0100;
        #1 check("p2_empty_io", 32'(io_in), 32'h0);
        tick();
        req_in = '0;
        check("p2_empty_uf", 32'(underflow), 32'h4);
        clr_err = 1'b1; tick(); clr_err = 1'b0;

        // port 0: fill, then push+pop on full
        for (int i = 0; i < 4; i++) begin
            drive_in(0, 19'(10 + i));
            tick();
        end
        s_valid = '0;
        check("p0_full", 32'(s_ready[0]), 32'h0);
        s_data[0 +: NBIN] = 19'd99;
        s_valid[0] = 1'b1;
        req_in = 4'b0001;
        read_in("p0_pop_on_full");
        tick();
        s_valid = '0;
        req_in = '0;
        check("p0_ready_again", 32'(s_ready[0]), 32'h1);
        req_in = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            read_in("p0_drain");
            tick();
        end
        #1 check("p0_refused_push", 32'(io_in), 32'h0);
        req_in = '0;
        check("p0_no_uf", 32'(underflow), 32'h0);

        // port 1 empty read, clear, clear coincident with new event
        req_in = 4'b0010;
        #1 check("p1_io_in", 32'(io_in), 32'h0);
        tick();
        req_in = '0;
        check("p1_uf", 32'(underflow), 32'h2);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("p1_clr", 32'(underflow), 32'h0);
        clr_err = 1'b1; req_in = 4'b0010; tick();
        clr_err = 1'b0; req_in = '0;
        check("p1_set_wins", 32'(underflow), 32'h2);
        clr_err = 1'b1; tick(); clr_err = 1'b0;

        // output capture, overwrite, capture with drain
        capture(0, 4'b0001, 28'h0001234);
        check("o0_valid", 32'(m_valid), 32'h1);
        check("o0_no_of", 32'(overflow), 32'h0);
        capture(0, 4'b0001, 28'h0005678);
        check("o0_of", 32'(overflow), 32'h1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        m_ready = 4'b0001;
        capture(0, 4'b0001, 28'h0009abc);
        check("o0_drain_cap_of", 32'(overflow), 32'h0);
        check("o0_drain_cap_v", 32'(m_valid), 32'h1);
        tick();
        m_ready = '0;
        check("o0_drained", 32'(m_valid), 32'h0);
        capture(1, 4'b0110, 28'hABCDEF1);
        check("o_multihot", 32'(m_valid), 32'h2);

        // async reset mid-stream
        drive_in(3, 19'h12345); tick();
        drive_in(3, 19'h00042); tick();
        s_valid = '0;
        req_in = 4'b1000;
        read_in("p3_head");
        rst = 1'b0;
        #1;
        check("arst_io_in", 32'(io_in), 32'h0);
        check("arst_m_valid", 32'(m_valid), 32'h0);
        check("arst_s_ready", 32'(s_ready), 32'h0);
        q_in.delete();
        req_in = '0;
        tick();
        rst = 1'b1;
        tick();
        req_in = 4'b1000;
        #1 check("post_rst_io_in", 32'(io_in), 32'h0);
        req_in = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_port_ctrl.md
# io_port_ctrl

I/O port controller between the external sample streams and the float processor core's decoded port strobes. It buffers up to four independent 19-bit integer input streams in per-port FIFOs and presents the head sample of the requested port on `io_in` when the core strobes `req_in`. It captures `io_out` into per-port output registers on `out_en` and drains them over valid/ready. Underflow and overflow are reported as sticky per-port flags, because the core cannot stall.

## Interface
- `NUIOIN`, 4: number of input ports (matches core input port count).
- `NUIOOU`, 4: number of output ports.
- `NBIN`, 19: input sample width, signed int.
- `NBOUT`, 28: output sample width, signed int.
- `DEPTH`, 4: per-input-port FIFO depth, power of 2, ≥2.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `s_data`  in  NUIOIN*NBIN  input samples, port k at bits [k*NBIN +: NBIN].
- `s_valid`  in  NUIOIN  per-port source valid.
- `s_ready`  out  NUIOIN  per-port FIFO not full.
- `req_in`  in  NUIOIN  one-hot read strobe from core input decoder.
- `io_in`  out  NBIN  head sample of selected port, to int-to-float converter.
- `out_en`  in  NUIOOU  one-hot write strobe from core output decoder.
- `io_out`  in  NBOUT  core result after float-to-int conversion.
- `m_data`  out  NUIOOU*NBOUT  output registers, port k at [k*NBOUT +: NBOUT].
- `m_valid`  out  NUIOOU  output register k holds unread data.
- `m_ready`  in  NUIOOU  sink accepts port k.
- `clr_err`  in  1  synchronous clear of sticky flags.
- `underflow`  out  NUIOIN  sticky: port read while its FIFO was empty.
- `overflow`  out  NUIOOU  sticky: unread output overwritten.

## Operation
- Reset (`rst`=0): all FIFOs empty; `s_ready`=0; `m_valid`, `m_data`, `underflow`, `overflow` = 0. `io_in` = 0 because the FIFOs are empty.
- Input push: `s_valid[k] & s_ready[k]` writes `s_data[k]` into FIFO k at the clock edge.
- `s_ready[k]` = `rst & !full[k]`. It does not look ahead to a same-cycle pop, so a push to a full FIFO is refused even when that FIFO is popped in the same cycle.
- Input pop: FIFOs are first-word-fall-through. `io_in` is combinational: the head of FIFO k, where k is the lowest set bit of `req_in`.
- When `req_in[k]`=1 and FIFO k is non-empty, FIFO k pops at the edge.
- Same-cycle push and pop on a non-full FIFO both take effect and the occupancy is unchanged.
- Empty read: when `req_in[k]`=1 and FIFO k is empty, `io_in` = 0, nothing pops, and `underflow[k]` sets at the edge.
- `req_in` all zero: `io_in` = 0.
- `req_in` multi-hot is illegal. Only the lowest set bit is serviced, and the other ports neither pop nor flag.
- Output capture: `out_en[k]` loads `io_out` into `m_data[k]` and sets `m_valid[k]` at the edge. `out_en` multi-hot: lowest set bit only.
- Output drain: `m_valid[k] & m_ready[k]` with no capture on port k clears `m_valid[k]`.
- Overwrite: `out_en[k]` while `m_valid[k]=1 & m_ready[k]=0` loads the new value and sets `overflow[k]`.
- `out_en[k]` and `m_ready[k]` in the same cycle: the old value is consumed, the new value is loaded, `m_valid` stays 1, and no overflow is flagged.
- `clr_err`: clears all sticky flags at the edge. If a new error event occurs in the same cycle, the set wins.
- FIFO pointers are log2(DEPTH)+1 bits wide and wrap naturally. full = MSBs differ and LSBs equal; empty = pointers equal.

## Timing
- Input path latency: a sample pushed at edge n can be read through `io_in` from cycle n+1.
- `io_in` has zero-cycle combinational latency from `req_in`. The path is a FIFO head mux plus a priority select, with no register.
- Output path latency: `io_out` captured at edge n appears on `m_data`/`m_valid` in cycle n+1.
- Flags assert in the cycle after the offending edge and stay set until `clr_err` or reset.
- Reset asserted mid-stream: every FIFO entry and output register is discarded immediately, asynchronously. Sources must re-send.

## Structure
- Shared package `io_port_pkg`: default widths (19/28), default port counts (4), `DEPTH` default, and a lowest-set-bit function used by both the input and output selects.
- Sub-module `port_fifo`: parameterised by `NBIN` and `DEPTH`, first-word-fall-through, with push/pop/full/empty. Instantiate it NUIOIN times with a generate loop.
- The output registers and flag logic stay inline.

## Test plan
- Reset release: all outputs 0; `s_ready`=4'b1111 one cycle after `rst` rises.
- Push 5, -3, 7 on port 2, then strobe `req_in`=4'b0100 for three cycles → `io_in` = 5, -3, 7 in order; FIFO 2 empty afterwards; `underflow`=0.
- Fill port 0 to DEPTH=4 → `s_ready[0]`=0. Then push and pop in the same cycle → push refused, occupancy 3, `s_ready[0]`=1 next cycle.
- `req_in`=4'b0010 with FIFO 1 empty → `io_in`=0, `underflow[1]`=1 next cycle. `clr_err` then clears it. `clr_err` coincident with a new empty read → flag stays 1.
- `out_en`=4'b0001 with `io_out`=28'h0001234, `m_ready`=0 → `m_data[0]`=0x1234, `m_valid[0]`=1. A second `out_en` with 0x5678 → `overflow[0]`=1, `m_data[0]`=0x5678. Capture plus `m_ready` in the same cycle → no flag.
- Assert `rst` low with 2 entries in FIFO 3 and `m_valid[1]`=1 → FIFO empty and `m_valid`=0 immediately, without waiting for a clock edge.
